// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker producing the ID-stage stall for the RV32I stall pipeline.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a retiring write-back clears busy in the same cycle.
module reg_scoreboard #(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inst_d_i,
  input  logic        issue_i,
  input  logic        regwen_d_i,
  input  logic        flush_i,
  input  logic        retire_i,
  input  logic [4:0]  retire_rd_i,
  output logic        stall_o,
  output logic [2:0]  pending_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [2:0]       PendMax = 3'(MAX_PEND);

  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]             pending_q, pending_d;
  logic                   err_q, err_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       used_rs1, used_rs2;
  logic       busy_rs1, busy_rs2;
  logic       ret, ret_ok, accept;
  logic       unused_inst;

  assign opcode      = inst_d_i[6:0];
  assign rd          = inst_d_i[11:7];
  assign rs1         = inst_d_i[19:15];
  assign rs2         = inst_d_i[24:20];
  assign unused_inst = ^{inst_d_i[31:25], inst_d_i[14:12]};

  always_comb begin
    used_rs1 = 1'b0;
    used_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        used_rs1 = 1'b1;
        used_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: used_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign ret    = retire_i & (retire_rd_i != 5'd0);
  assign ret_ok = ret & (cnt_q[retire_rd_i] != '0);

  always_comb begin
    busy_rs1 = (rs1 != 5'd0) && (cnt_q[rs1] != '0);
    busy_rs2 = (rs2 != 5'd0) && (cnt_q[rs2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Write-through register file: the last pending write retiring now is visible to ID.
    if (ret && (retire_rd_i == rs1) && (cnt_q[rs1] == CntOne)) busy_rs1 = 1'b0;
    if (ret && (retire_rd_i == rs2) && (cnt_q[rs2] == CntOne)) busy_rs2 = 1'b0;
`endif
  end

  assign stall_o = issue_i & ~flush_i &
                   ((used_rs1 & busy_rs1) | (used_rs2 & busy_rs2) |
                    (regwen_d_i & (rd != 5'd0) &
                     ((pending_q == PendMax) | (cnt_q[rd] == CntMax))));

  assign accept = issue_i & ~stall_o & ~flush_i & regwen_d_i & (rd != 5'd0);

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned r = 1; r < 32; r++) begin
      if (accept && (rd == 5'(r)) && !(ret_ok && (retire_rd_i == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (ret_ok && (retire_rd_i == 5'(r)) && !(accept && (rd == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    pending_d = pending_q;
    if (accept && !ret_ok) begin
      pending_d = pending_q + 3'd1;
    end else if (ret_ok && !accept && (pending_q != 3'd0)) begin
      pending_d = pending_q - 3'd1;
    end
  end

  assign err_d       = err_q | (ret & ~ret_ok);
  assign stall_cnt_d = (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                    : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      pending_q   <= 3'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pending_o   = pending_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus pushes expected outputs, a negedge monitor checks.
module tb_reg_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] inst_d_i = 32'd0;
  logic        issue_i = 1'b0;
  logic        regwen_d_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        retire_i = 1'b0;
  logic [4:0]  retire_rd_i = 5'd0;
  logic        stall_o;
  logic [2:0]  pending_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic [2:0]  pend;
    logic        err;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic [31:0] Sc = 32'd2;
`else
  localparam logic [31:0] Sc = 32'd3;
`endif

  reg_scoreboard dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inst_d_i    (inst_d_i),
    .issue_i     (issue_i),
    .regwen_d_i  (regwen_d_i),
    .flush_i     (flush_i),
    .retire_i    (retire_i),
    .retire_rd_i (retire_rd_i),
    .stall_o     (stall_o),
    .pending_o   (pending_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] a,
                                        input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] a);
    return {12'd1, a, 3'd0, rd, 7'b0010011};
  endfunction

  task automatic push(input string name, input logic st, input logic [2:0] pd,
                      input logic er, input logic [31:0] sc);
    exp_t e;
    e.name = name; e.stall = st; e.pend = pd; e.err = er; e.scnt = sc;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge, queue the outputs expected this cycle.
  task automatic cyc(input string name, input logic iss, input logic wen, input logic [31:0] ins,
                     input logic fl, input logic rt, input logic [4:0] rrd,
                     input logic st, input logic [2:0] pd, input logic er,
                     input logic [31:0] sc);
    @(posedge clk_i);
    #1;
    issue_i = iss; regwen_d_i = wen; inst_d_i = ins; flush_i = fl;
    retire_i = rt; retire_rd_i = rrd;
    push(name, st, pd, er, sc);
  endtask

  task automatic idle(input string name, input logic [2:0] pd, input logic er,
                      input logic [31:0] sc);
    cyc(name, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, pd, er, sc);
  endtask

  task automatic ret(input string name, input logic [4:0] r, input logic [2:0] pd,
                     input logic er, input logic [31:0] sc);
    cyc(name, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, r, 1'b0, pd, er, sc);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 4;
      if (stall_o !== e.stall) begin
        n_fail++;
        $display("FAIL %s stall_o: got %b want %b", e.name, stall_o, e.stall);
      end
      if (pending_o !== e.pend) begin
        n_fail++;
        $display("FAIL %s pending_o: got %0d want %0d", e.name, pending_o, e.pend);
      end
      if (err_o !== e.err) begin
        n_fail++;
        $display("FAIL %s err_o: got %b want %b", e.name, err_o, e.err);
      end
      if (stall_cnt_o !== e.scnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt_o: got %0d want %0d", e.name, stall_cnt_o, e.scnt);
      end
    end
  end

  initial begin
    // Reset
    idle("reset_hold", 3'd0, 1'b0, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle("reset_rel", 3'd0, 1'b0, 32'd0);

    // RAW: addi x5 then add x6,x5,x5; x5 retires three cycles after its issue
    cyc("raw_prod", 1, 1, enc_i(5'd5, 5'd0), 0, 0, 5'd0, 0, 3'd0, 0, 32'd0);
    cyc("raw_st1",  1, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 0, 5'd0, 1, 3'd1, 0, 32'd0);
    cyc("raw_st2",  1, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 0, 5'd0, 1, 3'd1, 0, 32'd1);
`ifdef SCOREBOARD_WB_BYPASS_EN
    cyc("raw_wb",   1, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 1, 5'd5, 0, 3'd1, 0, 32'd2);
`else
    cyc("raw_wb",   1, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 1, 5'd5, 1, 3'd1, 0, 32'd2);
    cyc("raw_go",   1, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 0, 5'd0, 0, 3'd0, 0, 32'd3);
`endif
    idle("raw_after", 3'd1, 1'b0, Sc);
    ret("raw_ret6", 5'd6, 3'd1, 1'b0, Sc);
    idle("raw_clean", 3'd0, 1'b0, Sc);

    // x0 destination and opcode without sources
    cyc("x0_dest",  1, 1, enc_i(5'd0, 5'd1), 0, 0, 5'd0, 0, 3'd0, 0, Sc);
    cyc("x7_prod",  1, 1, enc_i(5'd7, 5'd0), 0, 0, 5'd0, 0, 3'd0, 0, Sc);
    cyc("lui_nosrc", 1, 1, 32'h0073_8037, 0, 0, 5'd0, 0, 3'd1, 0, Sc);
    ret("x7_ret", 5'd7, 3'd1, 1'b0, Sc);
    idle("x0_clean", 3'd0, 1'b0, Sc);

    // Capacity limit
    cyc("cap_x1", 1, 1, enc_i(5'd1, 5'd0), 0, 0, 5'd0, 0, 3'd0, 0, Sc);
    cyc("cap_x2", 1, 1, enc_i(5'd2, 5'd0), 0, 0, 5'd0, 0, 3'd1, 0, Sc);
    cyc("cap_x3", 1, 1, enc_i(5'd3, 5'd0), 0, 0, 5'd0, 0, 3'd2, 0, Sc);
    cyc("cap_x4_full", 1, 1, enc_i(5'd4, 5'd0), 0, 0, 5'd0, 1, 3'd3, 0, Sc);
    cyc("cap_x4_ret1", 1, 1, enc_i(5'd4, 5'd0), 0, 1, 5'd1, 1, 3'd3, 0, Sc + 32'd1);
    cyc("cap_x4_go", 1, 1, enc_i(5'd4, 5'd0), 0, 0, 5'd0, 0, 3'd2, 0, Sc + 32'd2);
    idle("cap_after", 3'd3, 1'b0, Sc + 32'd2);
    ret("cap_ret2", 5'd2, 3'd3, 1'b0, Sc + 32'd2);
    ret("cap_ret3", 5'd3, 3'd2, 1'b0, Sc + 32'd2);
    ret("cap_ret4", 5'd4, 3'd1, 1'b0, Sc + 32'd2);
    idle("cap_clean", 3'd0, 1'b0, Sc + 32'd2);

    // Flush: a squashed writer of x9 that would otherwise stall on x10
    cyc("fl_x10", 1, 1, enc_i(5'd10, 5'd0), 0, 0, 5'd0, 0, 3'd0, 0, Sc + 32'd2);
    cyc("fl_squash", 1, 1, enc_r(5'd9, 5'd10, 5'd10), 1, 0, 5'd0, 0, 3'd1, 0, Sc + 32'd2);
    cyc("fl_reader", 1, 1, enc_r(5'd11, 5'd9, 5'd9), 0, 0, 5'd0, 0, 3'd1, 0, Sc + 32'd2);
    idle("fl_after", 3'd2, 1'b0, Sc + 32'd2);
    ret("fl_ret10", 5'd10, 3'd2, 1'b0, Sc + 32'd2);
    ret("fl_ret11", 5'd11, 3'd1, 1'b0, Sc + 32'd2);
    idle("fl_clean", 3'd0, 1'b0, Sc + 32'd2);

    // Error: retire of an idle register
    ret("err_ret12", 5'd12, 3'd0, 1'b0, Sc + 32'd2);
    idle("err_set", 3'd0, 1'b1, Sc + 32'd2);
    cyc("err_x13", 1, 1, enc_i(5'd13, 5'd0), 0, 0, 5'd0, 0, 3'd0, 1, Sc + 32'd2);
    idle("err_sticky", 3'd1, 1'b1, Sc + 32'd2);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    push("mid_reset", 1'b0, 3'd0, 1'b0, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle("post_reset", 3'd0, 1'b0, 32'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
